// File: rtl/channel_merge_rr.sv
// rtl/channel_merge_rr.sv - M-input round-robin channel merge with optional packet lock and tagged output FIFO
// Grants come only from registered state and in_v, so in_a has no combinational path from out_a.
module channel_merge_rr #(
    parameter int N      = 8,
    parameter int M      = 4,
    parameter int TagW   = $clog2(M),
    parameter int PktLen = 1,
    parameter int D      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [M*N-1:0]      in_d,
    input  logic [M-1:0]        in_v,
    output logic [M-1:0]        in_a,
    output logic [N+TagW-1:0]   out_d,
    output logic                out_v,
    input  logic                out_a
);

    localparam int PW = $clog2(D);
    localparam int CW = (PktLen > 1) ? $clog2(PktLen + 1) : 1;

    logic [N+TagW-1:0] fifo [D];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW:0]       count;
    logic [TagW-1:0]   last_grant;
    logic [TagW-1:0]   lock_idx;
    logic [TagW-1:0]   grant;
    logic [TagW-1:0]   idx;
    logic [CW-1:0]     word_ct;
    logic              locked;
    logic              full;
    logic              any_req;
    logic              wr;
    logic              rd;
    logic [N-1:0]      in_word [M];

    for (genvar i = 0; i < M; i++) begin : g_split
        assign in_word[i] = in_d[i*N +: N];
    end

    assign full  = (count == (PW+1)'(D));
    assign out_v = (count != '0);
    assign out_d = fifo[head];
    assign rd    = out_v & out_a;
    assign wr    = |in_a;

    always_comb begin
        in_a    = '0;
        grant   = last_grant;
        any_req = 1'b0;
        idx     = '0;
        if (locked) begin
            grant   = lock_idx;
            any_req = in_v[lock_idx];
        end else begin
            // Scan farthest-first so the nearest valid index after last_grant wins.
            for (int k = M; k >= 1; k--) begin
                idx = TagW'((int'(last_grant) + k) % M);
                if (in_v[idx]) begin
                    grant   = idx;
                    any_req = 1'b1;
                end
            end
        end
        if (any_req && !full && !reset) begin
            in_a[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            fifo[tail] <= {grant, in_word[grant]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            last_grant <= TagW'(M - 1);
            lock_idx   <= '0;
            word_ct    <= '0;
            locked     <= 1'b0;
        end else begin
            if (wr) begin
                tail <= tail + 1'b1;
            end
            if (rd) begin
                head <= head + 1'b1;
            end
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr) begin
                if (PktLen == 1) begin
                    last_grant <= grant;
                end else if (!locked) begin
                    locked     <= 1'b1;
                    lock_idx   <= grant;
                    word_ct    <= CW'(1);
                    last_grant <= grant;
                end else if (word_ct == CW'(PktLen - 1)) begin
                    // Final word of the packet: release and resume round-robin after lock_idx.
                    locked     <= 1'b0;
                    word_ct    <= '0;
                    last_grant <= lock_idx;
                end else begin
                    word_ct <= word_ct + 1'b1;
                end
            end
        end
    end

    a_ack_implies_valid: assert property (@(posedge clk) (in_a & ~in_v) == '0);
    a_single_ack:        assert property (@(posedge clk) $onehot0(in_a));
    a_out_v_held:        assert property (@(posedge clk) disable iff (reset)
                                          (out_v && !out_a) |=> out_v);

endmodule

// File: tb/tb_channel_merge_rr.sv
// tb/tb_channel_merge_rr.sv - randomized and directed bench for channel_merge_rr with a queue-based reference model
module tb_channel_merge_rr;

    localparam int N  = 8;
    localparam int M  = 4;
    localparam int TW = 2;
    localparam int D  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             out_a = 1'b0;
    logic [M*N-1:0]   in_d = '0;
    logic [M-1:0]     in_v = '0;
    logic [M-1:0]     in_a_w [2];
    logic             out_v_w [2];
    logic [N+TW-1:0]  out_d_w [2];

    int checks = 0;
    int errors = 0;

    // Reference model state: last granted index, words left in a locked packet, locked index.
    int lg [2] = '{M-1, M-1};
    int rem [2] = '{0, 0};
    int lidx [2] = '{0, 0};
    int acc [2] = '{0, 0};
    logic [N+TW-1:0] mq0 [$];
    logic [N+TW-1:0] mq1 [$];
    logic [N+TW-1:0] log0 [$];
    logic [N+TW-1:0] log1 [$];

    logic [3:0] lock_v [10] = '{4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0101,
                                4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101};

    always #5 clk = ~clk;

    channel_merge_rr #(.N(N), .M(M), .PktLen(1), .D(D)) u_rr (
        .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a_w[0]),
        .out_d(out_d_w[0]), .out_v(out_v_w[0]), .out_a(out_a));

    channel_merge_rr #(.N(N), .M(M), .PktLen(3), .D(D)) u_pkt (
        .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a_w[1]),
        .out_d(out_d_w[1]), .out_v(out_v_w[1]), .out_a(out_a));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_cycle();
        for (int k = 0; k < 2; k++) begin
            int pk;
            int sz;
            int g;
            logic [M-1:0] ea;
            logic [N+TW-1:0] front;
            pk = (k == 0) ? 1 : 3;
            sz = (k == 0) ? mq0.size() : mq1.size();
            front = '0;
            if (sz > 0) front = (k == 0) ? mq0[0] : mq1[0];
            g = -1;
            if (!reset && sz < D) begin
                if (rem[k] > 0) begin
                    if (in_v[lidx[k]]) g = lidx[k];
                end else begin
                    for (int j = 1; j <= M; j++) begin
                        if (g < 0 && in_v[(lg[k] + j) % M]) g = (lg[k] + j) % M;
                    end
                end
            end
            ea = '0;
            if (g >= 0) ea[g] = 1'b1;
            check($sformatf("in_a[%0d]", k), 32'(in_a_w[k]), 32'(ea));
            check($sformatf("out_v[%0d]", k), 32'(out_v_w[k]), 32'(sz != 0));
            if (sz != 0) check($sformatf("out_d[%0d]", k), 32'(out_d_w[k]), 32'(front));
            if (!reset && out_v_w[k] && out_a) begin
                if (k == 0) log0.push_back(out_d_w[k]);
                else        log1.push_back(out_d_w[k]);
            end
            if (in_a_w[k] != '0) acc[k]++;
            if (reset) begin
                if (k == 0) mq0.delete(); else mq1.delete();
                lg[k]  = M - 1;
                rem[k] = 0;
            end else begin
                if (sz > 0 && out_a) begin
                    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
                end
                if (g >= 0) begin
                    if (k == 0) mq0.push_back({TW'(g), in_d[g*N +: N]});
                    else        mq1.push_back({TW'(g), in_d[g*N +: N]});
                    if (pk == 1) begin
                        lg[k] = g;
                    end else if (rem[k] == 0) begin
                        rem[k]  = pk - 1;
                        lidx[k] = g;
                    end else begin
                        rem[k]--;
                        if (rem[k] == 0) lg[k] = lidx[k];
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_v  = '0;
        out_a = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic check_log(input string nm, input int k, input int s, input int i,
                             input logic [N+TW-1:0] exp, input bit tag_only);
        int sz;
        logic [N+TW-1:0] v;
        sz = (k == 0) ? log0.size() : log1.size();
        if (s + i >= sz) begin
            check({nm, "_missing"}, 32'(sz), 32'(s + i + 1));
        end else begin
            v = (k == 0) ? log0[s+i] : log1[s+i];
            if (tag_only) check(nm, 32'(v[N+TW-1:N]), 32'(exp[N+TW-1:N]));
            else          check(nm, 32'(v), 32'(exp));
        end
    endtask

    initial begin
        int s;
        int a0;
        int a1;
        fork
            begin
                @(posedge clk);
                forever begin
                    @(negedge clk);
                    model_cycle();
                end
            end
        join_none

        // Reset and idle.
        reset = 1'b1;
        tick();
        check("rst_in_a", 32'(in_a_w[0] | in_a_w[1]), 0);
        check("rst_out_v", 32'(out_v_w[0] | out_v_w[1]), 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        check("idle_out_v", 32'(out_v_w[0] | out_v_w[1]), 0);
        check("idle_in_a", 32'(in_a_w[0] | in_a_w[1]), 0);

        // Full contention.
        in_d  = {8'h13, 8'h12, 8'h11, 8'h10};
        in_v  = 4'hF;
        out_a = 1'b1;
        s = log0.size();
        a1 = log1.size();
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            check_log("contend_word", 0, s, i, {TW'(i % 4), 8'(8'h10 + i % 4)}, 1'b0);
            check_log("contend_pkt_tag", 1, a1, i, {TW'(i / 3), 8'h00}, 1'b1);
        end

        // Single source, then a second joins.
        do_reset();
        out_a = 1'b1;
        in_v  = 4'b0010;
        s = log0.size();
        repeat (4) tick();
        in_v = 4'b1010;
        repeat (6) tick();
        for (int i = 0; i < 8; i++) begin
            check_log("join_tag", 0, s, i, {TW'((i >= 4 && i % 2 == 0) ? 3 : 1), 8'h00}, 1'b1);
        end

        // Backpressure.
        do_reset();
        in_v = 4'hF;
        a0 = acc[0];
        a1 = acc[1];
        repeat (5) tick();
        check("bp_accepted0", 32'(acc[0] - a0), 2);
        check("bp_accepted1", 32'(acc[1] - a1), 2);
        check("bp_in_a_full", 32'(in_a_w[0]), 0);
        s = log0.size();
        out_a = 1'b1;
        repeat (3) tick();
        check_log("bp_first", 0, s, 0, {2'd0, 8'h10}, 1'b0);
        check_log("bp_second", 0, s, 1, {2'd1, 8'h11}, 1'b0);

        // Packet lock with the locked source dropping valid mid-packet.
        do_reset();
        out_a = 1'b1;
        s = log1.size();
        for (int i = 0; i < 10; i++) begin
            in_v = lock_v[i];
            #1;
            if (i == 2 || i == 3) check("lock_stall", 32'(in_a_w[1]), 0);
            tick();
        end
        in_v = '0;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            check_log("lock_tag", 1, s, i, {TW'(i < 3 ? 0 : 2), 8'h00}, 1'b1);
        end

        // Reset in the middle of a locked packet.
        do_reset();
        out_a = 1'b1;
        in_v  = 4'b0010;
        repeat (2) tick();
        check("midrst_buffered", 32'(out_v_w[1]), 1);
        reset = 1'b1;
        in_v  = 4'hF;
        #1;
        check("midrst_in_a", 32'(in_a_w[1]), 0);
        tick();
        reset = 1'b0;
        #1;
        check("midrst_out_v", 32'(out_v_w[1]), 0);
        check("midrst_restart", 32'(in_a_w[1]), 32'h1);
        tick();
        check("midrst_relock", 32'(in_a_w[1]), 32'h1);

        // Randomized traffic, backpressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            in_v  = 4'($urandom);
            in_d  = 32'($urandom);
            out_a = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;
        in_v  = '0;
        out_a = 1'b1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/channel_merge_rr.md
Name: channel_merge_rr

Overview:
- M-way generalisation of the two-input channel merge.
- Round-robin arbitration over M input channels of width N.
- Optional packet lock: a grant is held for PktLen consecutive words from the same input.
- Output is buffered in a D-entry registered FIFO and tagged with the source index.
- Breaks the combinational out.a -> in.a path.
- Sits between per-core/per-source traffic generators and a shared downstream Channel, e.g. the host-bound stream.

Parameters:
- N, 8: data width of each input channel.
- M, 4: number of input channels; M >= 2.
- TagW, $clog2(M): width of the source-index tag.
- PktLen, 1: words per locked packet; PktLen >= 1; 1 = per-word round-robin.
- D, 2: output FIFO depth; power of two, D >= 2.

Ports:
- clk  input  1  clock, all state on posedge.
- reset  input  1  synchronous, active-high reset.
- in  ChannelArray #(N,M)  M x (N+2)  input channels; d/v driven by sources, a driven here.
- out  Channel #(N+TagW)  N+TagW+2  output channel; d = {tag, data}, tag in MSBs; v/d driven here, a by sink.

Behaviour:
- Reset: sampled on posedge clk only; all state cleared on the edge where reset = 1.
  - FIFO count = 0, head = tail = 0, last_grant = M-1, word_ct = 0, locked = 0.
  - out.v = 0 and in.a = 0 on the cycle after the reset edge.
  - FIFO storage is not cleared; out.d is don't-care while out.v = 0.
- Reset mid-operation: an in-flight packet lock is dropped and buffered words are discarded. No in.a is asserted in any cycle where reset = 1.
- Accept condition: accept = ~full, where full = (count == D). accept is registered state only; in.a never depends combinationally on out.a.
- Grant, unlocked:
  - g = first index with in.v = 1, scanning last_grant+1, last_grant+2, ... modulo M.
  - If accept and any in.v: in.a[g] = 1, all other in.a = 0; write {g, in.d[g]} at tail.
  - If accept and no in.v, or if full: all in.a = 0.
- Grant, locked (PktLen > 1):
  - The first word accepted from g sets locked = 1, lock_idx = g, word_ct = 1.
  - While locked, only lock_idx is eligible. Other valid inputs wait even if lock_idx has in.v = 0, which stalls the merge.
  - Each accepted word increments word_ct. On acceptance of word PktLen: locked = 0, word_ct = 0, last_grant = lock_idx.
- last_grant update: in unlocked mode, last_grant <= g on every accepted word.
- Latency:
  - A word accepted at edge k appears with out.v = 1 in cycle k+1, i.e. 1 cycle.
  - Steady-state throughput is 1 word/cycle with D >= 2.
- Output side:
  - out.v = (count != 0); out.d = fifo[head].
  - Read on edge where out.v & out.a.
- Simultaneous read and write: count is unchanged, and head and tail both advance.
- Write while full: impossible, because in.a = 0 when full.
- Pointer wrap: head and tail are $clog2(D) bits and wrap naturally; count is $clog2(D)+1 bits.
- Fairness: with all M inputs continuously valid and PktLen = 1, each input receives exactly one grant per M accepted words.
- Protocol checks (simulation-only assertions):
  - in.a[i] implies in.v[i].
  - At most one in.a bit is high.
  - out.v must not fall while a word is buffered.
- Input drop: an input may drop v unacked in unlocked mode; it simply loses eligibility.

Test Plan:
- Reset and idle: reset high 2 cycles, all in.v = 0 -> out.v = 0, in.a = 0 throughout; count = 0.
- Full contention: M=4, PktLen=1, all inputs valid with d = 8'h10+i, out.a tied 1 -> out.d tags 0,1,2,3,0,1,... one word/cycle after the first cycle of latency.
- Single source then contention: only in1 valid, then in3 joins while out.a = 1 -> in1 words tag 1 uninterrupted until in3 valid, then grants alternate 3,1,3,1.
- Backpressure: all valid, out.a = 0 for 5 cycles -> exactly D=2 words accepted (tags 0,1), then in.a = 0 until out.a = 1; no word lost or duplicated.
- Packet lock: PktLen=3, in0 and in2 valid with in0 dropping v for 2 cycles mid-packet -> output tags 0,0,(stall),0,2,2,2; in2 is never granted during in0's packet.
- Reset mid-packet: PktLen=3, assert reset after word 2 of in1's packet with 1 word buffered -> next cycle out.v = 0. After release, arbitration restarts at index 0 (last_grant = M-1), with no residual lock.
